// File: rtl/mux_tx_4to1.sv
// 4:1 transmit byte serializer: samples four lanes every fourth clk_4f edge and emits them
// in lane order 0..3. Define MUX_TX_IDLE_EN to drive IDLE_WORD in empty slots.
module mux_tx_4to1 #(
  parameter int unsigned   BW        = 8,
  parameter logic [BW-1:0] IDLE_WORD = 8'hBC
) (
  input  logic          clk_4f,
  input  logic          reset_L,
  input  logic [BW-1:0] data_0,
  input  logic [BW-1:0] data_1,
  input  logic [BW-1:0] data_2,
  input  logic [BW-1:0] data_3,
  input  logic          valid_0,
  input  logic          valid_1,
  input  logic          valid_2,
  input  logic          valid_3,
  output logic [BW-1:0] data_000,
  output logic          valid_000,
  output logic          sample_req,
  output logic          active
);

`ifdef MUX_TX_IDLE_EN
  localparam bit IdleEn = 1'b1;
`else
  localparam bit IdleEn = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e               state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  // Lane 0 goes straight to the output on the sample edge, so only lanes 1..3 are held.
  logic [3:1][BW-1:0]   hold_data_q, hold_data_d;
  logic [3:1]           hold_valid_q, hold_valid_d;
  logic [BW-1:0]        data_q, data_d;
  logic                 valid_q, valid_d;

  logic [3:0][BW-1:0]   lane_data;
  logic [3:0]           lane_valid;
  logic                 sample;
  logic                 slot_valid;
  logic [BW-1:0]        slot_data;
  logic                 slot_gate;

  assign lane_data  = {data_3, data_2, data_1, data_0};
  assign lane_valid = {valid_3, valid_2, valid_1, valid_0};
  assign sample     = (phase_q == 2'd3);

  always_comb begin
    phase_d      = phase_q + 2'd1;
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    slot_valid   = 1'b0;
    slot_data    = '0;
    slot_gate    = 1'b0;

    if (sample) begin
      unique case (state_q)
        StIdle:   state_d = (|lane_valid) ? StActive : StIdle;
        StActive: state_d = (|lane_valid) ? StActive : StIdle;
        default:  state_d = StIdle;
      endcase
      hold_data_d  = lane_data[3:1];
      hold_valid_d = lane_valid[3:1];
      slot_valid   = lane_valid[0];
      slot_data    = lane_data[0];
      // The frame that causes the transition already uses the new state.
      slot_gate    = (state_d == StActive);
    end else begin
      unique case (phase_q)
        2'd0: begin
          slot_valid = hold_valid_q[1];
          slot_data  = hold_data_q[1];
        end
        2'd1: begin
          slot_valid = hold_valid_q[2];
          slot_data  = hold_data_q[2];
        end
        2'd2: begin
          slot_valid = hold_valid_q[3];
          slot_data  = hold_data_q[3];
        end
        default: begin
          slot_valid = 1'b0;
          slot_data  = '0;
        end
      endcase
      slot_gate = (state_q == StActive);
    end

    valid_d = slot_valid & slot_gate;
    if (valid_d) begin
      data_d = slot_data;
    end else if (IdleEn) begin
      data_d = IDLE_WORD;
    end else begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      phase_q      <= 2'd0;
      state_q      <= StIdle;
      hold_data_q  <= '0;
      hold_valid_q <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
    end
  end

  assign data_000   = data_q;
  assign valid_000  = valid_q;
  assign sample_req = sample;
  assign active     = (state_q == StActive);

endmodule

// File: tb/tb_mux_tx_4to1.sv
// Self-checking bench for mux_tx_4to1: directed frame table, hand-written reset sequences and
// randomized traffic checked against a slot-queue reference model.
module tb_mux_tx_4to1;

`ifdef MUX_TX_IDLE_EN
  localparam bit IDLE_EN = 1'b1;
`else
  localparam bit IDLE_EN = 1'b0;
`endif
  localparam logic [7:0] IW = 8'hBC;

  logic             clk_4f = 1'b0;
  logic             reset_L = 1'b0;
  logic [3:0][7:0]  in_d = '0;
  logic [3:0]       in_v = '0;
  logic [7:0]       data_000;
  logic             valid_000, sample_req, active;

  int checks = 0;
  int errors = 0;

  always #5 clk_4f = ~clk_4f;

  mux_tx_4to1 dut (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .data_0    (in_d[0]),
    .data_1    (in_d[1]),
    .data_2    (in_d[2]),
    .data_3    (in_d[3]),
    .valid_0   (in_v[0]),
    .valid_1   (in_v[1]),
    .valid_2   (in_v[2]),
    .valid_3   (in_v[3]),
    .data_000  (data_000),
    .valid_000 (valid_000),
    .sample_req(sample_req),
    .active    (active)
  );

  // Reference model: each sampled frame becomes four output slots in a queue.
  typedef struct {
    logic       v;
    logic [7:0] d;
  } slot_t;

  slot_t      q[$];
  int         ph_m = 0;
  logic       m_v = 1'b0;
  logic [7:0] m_d = '0;
  logic       m_active = 1'b0;

  typedef struct {
    logic [3:0]      v;
    logic [3:0][7:0] d;
    logic [3:0]      ev;
    logic [3:0][7:0] ed;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    slot_t s;
    logic  anyv;
    @(posedge clk_4f);
    if (!reset_L) begin
      ph_m = 0; q.delete(); m_v = 1'b0; m_d = '0; m_active = 1'b0;
    end else begin
      if (ph_m == 3) begin
        anyv = |in_v;
        for (int k = 0; k < 4; k++) begin
          s.v = in_v[k] & anyv;
          s.d = in_d[k];
          q.push_back(s);
        end
        m_active = anyv;
      end
      if (q.size() > 0) s = q.pop_front();
      else begin s.v = 1'b0; s.d = '0; end
      m_v = s.v;
      if (s.v) m_d = s.d;
      else if (IDLE_EN) m_d = IW;
      ph_m = (ph_m + 1) % 4;
    end
    #1;
    chk("valid_000", {31'd0, valid_000}, {31'd0, m_v});
    chk("data_000", {24'd0, data_000}, {24'd0, m_d});
    chk("active", {31'd0, active}, {31'd0, m_active});
    chk("sample_req", {31'd0, sample_req}, {31'd0, (ph_m == 3)});
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < 4; k++) begin
      in_d[k] = 8'($urandom);
      in_v[k] = 1'($urandom);
    end
  endtask

  task automatic align();
    for (int i = 0; i < 8 && ph_m != 3; i++) step();
  endtask

  // Drive one frame in the cycle before its sample edge and compare its four slots.
  task automatic run_frame(input vec_t f, input string tag);
    in_v = f.v;
    in_d = f.d;
    for (int k = 0; k < 4; k++) begin
      step();
      chk({tag, "_v"}, {31'd0, valid_000}, {31'd0, f.ev[k]});
      chk({tag, "_d"}, {24'd0, data_000}, {24'd0, f.ed[k]});
      if (k == 0) begin
        chk({tag, "_active"}, {31'd0, active}, {31'd0, |f.v});
        randomize_inputs();
      end
    end
  endtask

  initial begin
    vec_t f;
    int   nv;
    logic [7:0] e;

    e = IDLE_EN ? IW : 8'hAA;
    tbl[0] = '{v: 4'b1111, d: {8'h44, 8'h33, 8'h22, 8'h11},
               ev: 4'b1111, ed: {8'h44, 8'h33, 8'h22, 8'h11}};
    tbl[1] = '{v: 4'b0101, d: {8'hDD, 8'hCC, 8'hBB, 8'hAA},
               ev: 4'b0101, ed: {(IDLE_EN ? IW : 8'hCC), 8'hCC, e, 8'hAA}};
    e = IDLE_EN ? IW : 8'hCC;
    tbl[2] = '{v: 4'b0000, d: {8'h88, 8'h77, 8'h66, 8'h55},
               ev: 4'b0000, ed: {e, e, e, e}};
    tbl[3] = '{v: 4'b1111, d: {8'h04, 8'h03, 8'h02, 8'h01},
               ev: 4'b1111, ed: {8'h04, 8'h03, 8'h02, 8'h01}};
    e = IDLE_EN ? IW : 8'h04;
    tbl[4] = '{v: 4'b1000, d: {8'h40, 8'h30, 8'h20, 8'h10},
               ev: 4'b1000, ed: {8'h40, e, e, e}};

    // Reset held for three edges, then release with idle lanes.
    reset_L = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("rst_data", {24'd0, data_000}, 32'd0);
    chk("rst_valid", {31'd0, valid_000}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    reset_L = 1'b1;
    in_v = '0;
    step();
    chk("rel1_sample_req", {31'd0, sample_req}, 32'd0);
    step();
    chk("rel2_sample_req", {31'd0, sample_req}, 32'd0);
    step();
    chk("rel3_sample_req", {31'd0, sample_req}, 32'd1);

    // Directed frames: full, sparse, all-empty (return to idle), re-entry, sparse.
    for (int i = 0; i < 5; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

    // Back-to-back full frames carrying 00..0B.
    for (int fr = 0; fr < 3; fr++) begin
      f.v = 4'b1111;
      f.ev = 4'b1111;
      for (int k = 0; k < 4; k++) begin
        f.d[k] = 8'(fr * 4 + k);
        f.ed[k] = 8'(fr * 4 + k);
      end
      run_frame(f, "b2b");
    end

    // Reset one edge after sampling 01..04: only 01 may come out.
    align();
    in_v = 4'b1111;
    in_d = {8'h04, 8'h03, 8'h02, 8'h01};
    step();
    chk("mid_first_d", {24'd0, data_000}, 32'h01);
    chk("mid_first_v", {31'd0, valid_000}, 32'd1);
    reset_L = 1'b0;
    in_v = '0;
    step();
    chk("mid_rst_d", {24'd0, data_000}, 32'd0);
    chk("mid_rst_v", {31'd0, valid_000}, 32'd0);
    reset_L = 1'b1;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (valid_000) nv++;
    end
    chk("mid_no_emit", nv, 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      randomize_inputs();
      if ($urandom_range(0, 7) == 0) in_v = '0;
      if ($urandom_range(0, 7) == 0) in_v = 4'b1111;
      reset_L = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
